control_loop_scheduler: RTL and testbench

//   Sequences one iteration of the wall-follower control loop per sample tick
//   (tick_in is driven by a clk_enable divider): sensor read -> PID compute -> PWM update.

---
 rtl/control_loop_scheduler.sv | 127 ++++++++++++
 tb/tb_control_loop_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_loop_scheduler.sv
// Wall-follower control-loop sequencer: per sample tick, runs sensor -> PID -> PWM
// stages with start/done handshakes, a per-stage timeout guard and sticky status flags.
module control_loop_scheduler #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 16,
  parameter int LOOP_CNT_W     = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  input  logic                  tick_in,
  input  logic                  sense_done_in,
  input  logic                  pid_done_in,
  input  logic                  pwm_done_in,
  input  logic                  err_clr_in,
  output logic                  sense_start_out,
  output logic                  pid_start_out,
  output logic                  pwm_start_out,
  output logic                  busy_out,
  output logic                  overrun_out,
  output logic                  timeout_out,
  output logic [1:0]            timeout_stage_out,
  output logic [LOOP_CNT_W-1:0] loop_count_out
);

  // Encodings double as the timeout stage codes reported on timeout_stage_out.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SENSE_WAIT = 2'd1,
    PID_WAIT   = 2'd2,
    PWM_WAIT   = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic                 stage_done;
  logic                 timeout_hit;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    stage_done = 1'b0;
    case (state)
      SENSE_WAIT: stage_done = sense_done_in;
      PID_WAIT:   stage_done = pid_done_in;
      PWM_WAIT:   stage_done = pwm_done_in;
      default:    stage_done = 1'b0;
    endcase
    // A done arriving on the limit cycle wins over the timeout.
    timeout_hit = (state != IDLE) && !stage_done && (timer == TIMER_LIMIT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of its neighbours.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state             <= IDLE;
      timer             <= '0;
      sense_start_out   <= 1'b0;
      pid_start_out     <= 1'b0;
      pwm_start_out     <= 1'b0;
      busy_out          <= 1'b0;
      overrun_out       <= 1'b0;
      timeout_out       <= 1'b0;
      timeout_stage_out <= 2'd0;
      loop_count_out    <= '0;
    end else begin
      sense_start_out <= 1'b0;
      pid_start_out   <= 1'b0;
      pwm_start_out   <= 1'b0;

      // Sticky flags: a set event in the same cycle beats the clear.
      if (tick_in && state != IDLE) begin
        overrun_out <= 1'b1;
      end else if (err_clr_in) begin
        overrun_out <= 1'b0;
      end

      if (timeout_hit) begin
        timeout_out       <= 1'b1;
        timeout_stage_out <= state;
      end else if (err_clr_in) begin
        timeout_out       <= 1'b0;
        timeout_stage_out <= 2'd0;
      end

      case (state)
        IDLE: begin
          timer <= '0;
          if (tick_in && enable_in) begin
            state           <= SENSE_WAIT;
            sense_start_out <= 1'b1;
            busy_out        <= 1'b1;
          end
        end
        default: begin
          if (stage_done) begin
            timer <= '0;
            case (state)
              SENSE_WAIT: begin
                state         <= PID_WAIT;
                pid_start_out <= 1'b1;
              end
              PID_WAIT: begin
                state         <= PWM_WAIT;
                pwm_start_out <= 1'b1;
              end
              default: begin
                state          <= IDLE;
                busy_out       <= 1'b0;
                loop_count_out <= loop_count_out + 1'b1;
              end
            endcase
          end else if (timeout_hit) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_loop_scheduler.sv
// Directed bench for control_loop_scheduler: normal loop, timeout, done-at-limit,
// overrun/clear priority, async reset mid-sequence, disabled ticks and counter wrap.
module tb_control_loop_scheduler;

  localparam int TIMEOUT_CYCLES = 8;
  localparam int TIMER_W        = 4;
  localparam int LOOP_CNT_W     = 2;

  logic                  clk_in = 1'b0;
  logic                  reset_in;
  logic                  enable_in;
  logic                  tick_in;
  logic                  sense_done_in;
  logic                  pid_done_in;
  logic                  pwm_done_in;
  logic                  err_clr_in;
  logic                  sense_start_out;
  logic                  pid_start_out;
  logic                  pwm_start_out;
  logic                  busy_out;
  logic                  overrun_out;
  logic                  timeout_out;
  logic [1:0]            timeout_stage_out;
  logic [LOOP_CNT_W-1:0] loop_count_out;

  int total  = 0;
  int passed = 0;

  control_loop_scheduler #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_W        (TIMER_W),
    .LOOP_CNT_W     (LOOP_CNT_W)
  ) dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .enable_in         (enable_in),
    .tick_in           (tick_in),
    .sense_done_in     (sense_done_in),
    .pid_done_in       (pid_done_in),
    .pwm_done_in       (pwm_done_in),
    .err_clr_in        (err_clr_in),
    .sense_start_out   (sense_start_out),
    .pid_start_out     (pid_start_out),
    .pwm_start_out     (pwm_start_out),
    .busy_out          (busy_out),
    .overrun_out       (overrun_out),
    .timeout_out       (timeout_out),
    .timeout_stage_out (timeout_stage_out),
    .loop_count_out    (loop_count_out)
  );

  always #5 clk_in = ~clk_in;

  // {sense, pid, pwm} starts and {overrun, timeout, stage[1:0]} flags.
  wire [2:0] starts  = {sense_start_out, pid_start_out, pwm_start_out};
  wire [3:0] flags   = {overrun_out, timeout_out, timeout_stage_out};
  wire [9:0] all_out = {starts, busy_out, flags, loop_count_out};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
  endtask

  // Holds the given inputs for one cycle; returns 1 time unit after the edge.
  task automatic step(input logic tk, input logic sd, input logic pd,
                      input logic wd, input logic clr);
    tick_in       = tk;
    sense_done_in = sd;
    pid_done_in   = pd;
    pwm_done_in   = wd;
    err_clr_in    = clr;
    @(posedge clk_in);
    #1;
    tick_in       = 1'b0;
    sense_done_in = 1'b0;
    pid_done_in   = 1'b0;
    pwm_done_in   = 1'b0;
    err_clr_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_in      = 1'b1;
    enable_in     = 1'b1;
    tick_in       = 1'b0;
    sense_done_in = 1'b0;
    pid_done_in   = 1'b0;
    pwm_done_in   = 1'b0;
    err_clr_in    = 1'b0;
    #12;
    check("reset_outputs", 32'(all_out), 0);
    reset_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Normal loop: tick@0, sense_done@3, pid_done@6, pwm_done@9.
    step(1, 0, 0, 0, 0);
    check("n_sense_start", 32'(starts), 'b100);
    check("n_busy1", 32'(busy_out), 1);
    step(0, 0, 0, 0, 0);
    check("n_start_one_cycle", 32'(starts), 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("n_pid_start", 32'(starts), 'b010);
    idle(2);
    step(0, 0, 1, 0, 0);
    check("n_pwm_start", 32'(starts), 'b001);
    idle(2);
    check("n_busy9", 32'(busy_out), 1);
    step(0, 0, 0, 1, 0);
    check("n_busy10", 32'(busy_out), 0);
    check("n_loop_count", 32'(loop_count_out), 1);
    check("n_flags", 32'(flags), 0);

    // Done exactly on the limit cycle (timer=7) wins over timeout.
    step(1, 0, 0, 0, 0);
    check("lim_sense_start", 32'(starts), 'b100);
    idle(7);
    check("lim_busy_at_limit", 32'(busy_out), 1);
    step(0, 1, 0, 0, 0);
    check("lim_pid_start", 32'(starts), 'b010);
    check("lim_no_timeout", 32'(flags), 0);

    // PID stage never finishes: still waiting at S+7, timed out at S+8.
    idle(7);
    check("to_busy_s7", 32'(busy_out), 1);
    check("to_flags_s7", 32'(flags), 0);
    step(0, 0, 0, 0, 0);
    check("to_flags_s8", 32'(flags), 'b0110);
    check("to_busy_s8", 32'(busy_out), 0);
    step(0, 0, 0, 1, 0);
    idle(2);
    check("to_no_pwm_start", 32'(starts), 0);
    check("to_loop_unchanged", 32'(loop_count_out), 1);
    step(0, 0, 0, 0, 1);
    check("to_clear", 32'(flags), 0);

    // Overrun: second tick @5 while busy.
    step(1, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("ov_set", 32'(flags), 'b1000);
    check("ov_no_restart", 32'(starts), 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    check("ov_loop_count", 32'(loop_count_out), 2);
    step(0, 0, 0, 0, 0);
    check("ov_tick_dropped", 32'({starts, busy_out}), 0);
    step(0, 0, 0, 0, 1);
    check("ov_clear", 32'(flags), 0);

    // Clear together with a tick-while-busy: the set wins.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("ov_set2", 32'(overrun_out), 1);
    step(1, 0, 0, 0, 1);
    check("ov_set_beats_clear", 32'(overrun_out), 1);
    step(0, 0, 0, 0, 1);
    check("ov_clear_busy", 32'(overrun_out), 0);
    // Tick on the final WAIT cycle still counts as overrun.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    check("ov_final_wait", 32'({busy_out, overrun_out, loop_count_out}), 'b0111);
    step(0, 0, 0, 0, 0);
    check("ov_final_no_start", 32'(starts), 0);
    step(0, 0, 0, 0, 1);

    // Disabled ticks in IDLE are ignored; enable drop mid-loop does not abort; wrap.
    enable_in = 1'b0;
    step(1, 0, 0, 0, 0);
    check("dis_ignored", 32'({starts, busy_out, flags}), 0);
    step(1, 0, 0, 0, 0);
    check("dis_ignored2", 32'({starts, busy_out, flags}), 0);
    enable_in = 1'b1;
    step(1, 0, 0, 0, 0);
    check("en_sense_start", 32'(starts), 'b100);
    enable_in = 1'b0;
    step(0, 1, 0, 0, 0);
    check("en_drop_continues", 32'(starts), 'b010);
    step(1, 0, 0, 0, 0);
    check("dis_busy_overrun", 32'(overrun_out), 1);
    step(0, 0, 1, 0, 0);
    check("en_drop_pwm", 32'(starts), 'b001);
    step(0, 0, 0, 1, 0);
    check("wrap_loop_count", 32'(loop_count_out), 0);
    check("wrap_busy", 32'(busy_out), 0);
    enable_in = 1'b1;
    step(0, 0, 0, 0, 1);

    // Asynchronous reset while in PID_WAIT, then a fresh loop.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("rst_in_pid_wait", 32'({pid_start_out, busy_out}), 'b11);
    #2 reset_in = 1'b1;
    #1;
    check("rst_async_outputs", 32'(all_out), 0);
    #1 reset_in = 1'b0;
    @(posedge clk_in);
    #1;
    step(1, 0, 0, 0, 0);
    check("rst_restart", 32'({starts, busy_out}), 'b1001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
